// File: rtl/cordic_arbiter.sv
// Round-robin front end that shares one pipelined CORDIC magnitude engine among NUM_REQ requesters.
// Define CORDIC_ARB_STATS_EN to build the saturating grant/stall statistics counters.
module cordic_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = 32,
  parameter int LATENCY   = 12,
  parameter int MAX_OUTST = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [NUM_REQ-1:0]         req_valid_i,
  output logic [NUM_REQ-1:0]         req_ready_o,
  input  logic [NUM_REQ*WIDTH-1:0]   req_x_i,
  input  logic [NUM_REQ*WIDTH-1:0]   req_y_i,
  output logic                       cdc_valid_o,
  output logic [WIDTH-1:0]           cdc_x_o,
  output logic [WIDTH-1:0]           cdc_y_o,
  input  logic                       cdc_valid_i,
  input  logic [WIDTH-1:0]           cdc_data_i,
  output logic [NUM_REQ-1:0]         rsp_valid_o,
  output logic [WIDTH-1:0]           rsp_data_o,
  input  logic                       flush_i,
  output logic                       idle_o,
  output logic                       flush_done_o,
  output logic                       err_o,
  output logic [31:0]                grant_cnt_o,
  output logic [31:0]                stall_cnt_o
);

  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW  = $clog2(MAX_OUTST + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [IDW-1:0]     r_last;
  logic [CW-1:0]      r_outst [NUM_REQ];
  logic               r_cdc_valid;
  logic [IDW-1:0]     r_cdc_id;
  logic [WIDTH-1:0]   r_cdc_x;
  logic [WIDTH-1:0]   r_cdc_y;
  logic [LATENCY-1:0] r_tag_v;
  logic [IDW-1:0]     r_tag_id [LATENCY];
  logic [NUM_REQ-1:0] r_rsp_valid;
  logic [WIDTH-1:0]   r_rsp_data;
  logic               r_flush_done;
  logic               r_err;

  logic [NUM_REQ-1:0] w_elig;
  logic [NUM_REQ-1:0] w_inc;
  logic [NUM_REQ-1:0] w_dec;
  logic               w_found;
  logic [IDW-1:0]     w_gid;
  logic               w_grant_en;
  logic               w_acc;
  logic               w_inflight;
  logic               w_head_v;
  logic [IDW-1:0]     w_head_id;
  logic               w_rsp;
  logic               w_mismatch;

  always_comb begin
    for (int k = 0; k < NUM_REQ; k++) begin
      w_elig[k] = req_valid_i[k] && (r_outst[k] < CW'(MAX_OUTST));
    end
  end

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    w_found = 1'b0;
    w_gid   = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      if (!w_found && w_elig[(int'(r_last) + i) % NUM_REQ]) begin
        w_found = 1'b1;
        w_gid   = IDW'((int'(r_last) + i) % NUM_REQ);
      end
    end
  end

  assign w_grant_en  = !rst_i && ((r_state == S_RUN) || ((r_state == S_IDLE) && !flush_i));
  assign w_acc       = w_grant_en && w_found;
  assign req_ready_o = w_acc ? (NUM_REQ'(1) << w_gid) : '0;

  assign w_head_v   = r_tag_v[LATENCY-1];
  assign w_head_id  = r_tag_id[LATENCY-1];
  assign w_mismatch = (cdc_valid_i != w_head_v);
  assign w_rsp      = cdc_valid_i && w_head_v;
  assign w_inflight = r_cdc_valid || (|r_tag_v);

  always_comb begin
    for (int k = 0; k < NUM_REQ; k++) begin
      w_inc[k] = w_acc && (w_gid == IDW'(k));
      w_dec[k] = w_rsp && (w_head_id == IDW'(k));
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if ((|req_valid_i) && !flush_i) w_state_nxt = S_RUN;
      S_RUN:   if (flush_i) w_state_nxt = S_DRAIN;
      S_DRAIN: if (!w_inflight) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= S_IDLE;
      r_last       <= IDW'(NUM_REQ - 1);
      r_cdc_valid  <= 1'b0;
      r_cdc_id     <= '0;
      r_cdc_x      <= '0;
      r_cdc_y      <= '0;
      r_tag_v      <= '0;
      r_rsp_valid  <= '0;
      r_rsp_data   <= '0;
      r_flush_done <= 1'b0;
      r_err        <= 1'b0;
      for (int k = 0; k < NUM_REQ; k++) r_outst[k] <= '0;
      for (int i = 0; i < LATENCY; i++) r_tag_id[i] <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_flush_done <= (r_state == S_DRAIN) && !w_inflight;
      // Issue stage: register the granted operands for the engine.
      r_cdc_valid  <= w_acc;
      if (w_acc) begin
        r_last   <= w_gid;
        r_cdc_id <= w_gid;
        r_cdc_x  <= req_x_i[w_gid*WIDTH +: WIDTH];
        r_cdc_y  <= req_y_i[w_gid*WIDTH +: WIDTH];
      end
      // Tag stage: ownership travels beside the engine pipeline.
      r_tag_v     <= {r_tag_v[LATENCY-2:0], r_cdc_valid};
      r_tag_id[0] <= r_cdc_id;
      for (int i = 1; i < LATENCY; i++) r_tag_id[i] <= r_tag_id[i-1];
      // Response stage: route the engine result back to its owner.
      r_rsp_valid <= w_rsp ? (NUM_REQ'(1) << w_head_id) : '0;
      if (w_rsp) r_rsp_data <= cdc_data_i;
      if (w_mismatch) r_err <= 1'b1;
      for (int k = 0; k < NUM_REQ; k++) begin
        if (w_inc[k] && !w_dec[k] && (r_outst[k] != CW'(MAX_OUTST)))
          r_outst[k] <= r_outst[k] + CW'(1);
        else if (w_dec[k] && !w_inc[k] && (r_outst[k] != '0))
          r_outst[k] <= r_outst[k] - CW'(1);
      end
    end
  end

  assign cdc_valid_o  = r_cdc_valid;
  assign cdc_x_o      = r_cdc_x;
  assign cdc_y_o      = r_cdc_y;
  assign rsp_valid_o  = r_rsp_valid;
  assign rsp_data_o   = r_rsp_data;
  assign flush_done_o = r_flush_done;
  assign err_o        = r_err;
  assign idle_o       = (r_state == S_IDLE) && !(|r_tag_v);

`ifdef CORDIC_ARB_STATS_EN
  logic [31:0] r_grant_cnt;
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_grant_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_acc && (r_grant_cnt != '1)) r_grant_cnt <= r_grant_cnt + 32'd1;
      if ((|req_valid_i) && !w_acc && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign grant_cnt_o = r_grant_cnt;
  assign stall_cnt_o = r_stall_cnt;
`else
  assign grant_cnt_o = '0;
  assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_cordic_arbiter.sv
// Directed bench for cordic_arbiter with a behavioural 12-cycle magnitude engine attached.
module tb_cordic_arbiter;
  localparam int N = 4;
  localparam int W = 32;
  localparam int L = 12;
  localparam int M = 8;
`ifdef CORDIC_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst_i;
  logic [N-1:0]   req_valid_i;
  logic [N-1:0]   req_ready_o;
  logic [N*W-1:0] req_x_i;
  logic [N*W-1:0] req_y_i;
  logic           cdc_valid_o;
  logic [W-1:0]   cdc_x_o;
  logic [W-1:0]   cdc_y_o;
  logic           cdc_valid_i;
  logic [W-1:0]   cdc_data_i;
  logic [N-1:0]   rsp_valid_o;
  logic [W-1:0]   rsp_data_o;
  logic           flush_i;
  logic           idle_o;
  logic           flush_done_o;
  logic           err_o;
  logic [31:0]    grant_cnt_o;
  logic [31:0]    stall_cnt_o;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  cordic_arbiter #(.NUM_REQ(N), .WIDTH(W), .LATENCY(L), .MAX_OUTST(M)) dut (
    .clk_i(clk), .rst_i(rst_i), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_x_i(req_x_i), .req_y_i(req_y_i), .cdc_valid_o(cdc_valid_o), .cdc_x_o(cdc_x_o),
    .cdc_y_o(cdc_y_o), .cdc_valid_i(cdc_valid_i), .cdc_data_i(cdc_data_i),
    .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o), .flush_i(flush_i), .idle_o(idle_o),
    .flush_done_o(flush_done_o), .err_o(err_o), .grant_cnt_o(grant_cnt_o), .stall_cnt_o(stall_cnt_o)
  );

  // Behavioural engine: sqrt(x^2+y^2) in Q15.16, L cycles from valid-in to valid-out.
  function automatic logic [W-1:0] mag(input logic signed [W-1:0] x, input logic signed [W-1:0] y);
    real xr;
    real yr;
    xr = $itor(x) / 65536.0;
    yr = $itor(y) / 65536.0;
    return W'($rtoi($sqrt(xr * xr + yr * yr) * 65536.0 + 0.5));
  endfunction

  logic [L-1:0] eng_v = '0;
  logic [W-1:0] eng_d [L];
  logic         inj = 1'b0;

  always_ff @(posedge clk) begin
    eng_v    <= {eng_v[L-2:0], cdc_valid_o};
    eng_d[0] <= mag(cdc_x_o, cdc_y_o);
    for (int i = 1; i < L; i++) eng_d[i] <= eng_d[i-1];
  end

  assign cdc_valid_i = eng_v[L-1] | inj;
  assign cdc_data_i  = eng_d[L-1];

  task automatic cyc;
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset;
    rst_i = 1'b1;
    req_valid_i = '0;
    flush_i = 1'b0;
    repeat (3) cyc();
    rst_i = 1'b0;
    #1;
    n_chk++; if (idle_o !== 1'b1) $display("FAIL reset_idle: got %b want 1", idle_o); else n_pass++;
    n_chk++; if (req_ready_o !== 4'b0) $display("FAIL reset_ready: got %b want 0000", req_ready_o); else n_pass++;
    n_chk++; if (cdc_valid_o !== 1'b0) $display("FAIL reset_cdc_valid: got %b want 0", cdc_valid_o); else n_pass++;
    n_chk++; if (rsp_valid_o !== 4'b0) $display("FAIL reset_rsp_valid: got %b want 0000", rsp_valid_o); else n_pass++;
    n_chk++; if (err_o !== 1'b0) $display("FAIL reset_err: got %b want 0", err_o); else n_pass++;
    n_chk++; if (flush_done_o !== 1'b0) $display("FAIL reset_flush_done: got %b want 0", flush_done_o); else n_pass++;
    n_chk++; if (grant_cnt_o !== 32'd0) $display("FAIL reset_grant_cnt: got %0d want 0", grant_cnt_o); else n_pass++;
  endtask

  task automatic test_round_robin;
    logic [N-1:0] e;
    int k;
    for (int r = 0; r < N; r++) begin
      req_x_i[r*W +: W] = W'((r + 1) << 16);
      req_y_i[r*W +: W] = '0;
    end
    for (int c = 0; c < 20; c++) begin
      cyc();
      req_valid_i = (c < 5) ? 4'hF : 4'h0;
      #1;
      e = (c < 5) ? (4'b0001 << (c % 4)) : 4'b0000;
      n_chk++; if (req_ready_o !== e) $display("FAIL rr_ready c%0d: got %b want %b", c, req_ready_o, e); else n_pass++;
      if (c >= 1 && c <= 6) begin
        k = (c <= 5) ? ((c - 1) % 4) : 0;
        n_chk++; if (cdc_valid_o !== (c <= 5)) $display("FAIL rr_cdc_valid c%0d: got %b want %b", c, cdc_valid_o, (c <= 5)); else n_pass++;
        n_chk++; if (cdc_x_o !== W'((k + 1) << 16)) $display("FAIL rr_cdc_x c%0d: got %h want %h", c, cdc_x_o, W'((k + 1) << 16)); else n_pass++;
      end
      if (c >= 13) begin
        k = c - 14;
        e = (k >= 0 && k < 5) ? (4'b0001 << (k % 4)) : 4'b0000;
        n_chk++; if (rsp_valid_o !== e) $display("FAIL rr_rsp_valid c%0d: got %b want %b", c, rsp_valid_o, e); else n_pass++;
        if (k >= 0 && k < 5) begin
          n_chk++; if (rsp_data_o !== W'(((k % 4) + 1) << 16)) $display("FAIL rr_rsp_data c%0d: got %h want %h", c, rsp_data_o, W'(((k % 4) + 1) << 16)); else n_pass++;
        end
      end
    end
    req_valid_i = '0;
  endtask

  task automatic test_magnitude;
    int d;
    req_x_i[2*W +: W] = 32'h0003_0000;
    req_y_i[2*W +: W] = 32'h0004_0000;
    for (int c = 0; c < 17; c++) begin
      cyc();
      req_valid_i = (c == 0) ? 4'b0100 : 4'b0000;
      #1;
      if (c == 0) begin
        n_chk++; if (req_ready_o !== 4'b0100) $display("FAIL mag_ready: got %b want 0100", req_ready_o); else n_pass++;
      end
      if (c == 1) begin
        n_chk++; if (cdc_valid_o !== 1'b1 || cdc_x_o !== 32'h30000 || cdc_y_o !== 32'h40000)
          $display("FAIL mag_cdc_ops: got v=%b x=%h y=%h want v=1 x=00030000 y=00040000", cdc_valid_o, cdc_x_o, cdc_y_o); else n_pass++;
      end
      if (c == 13 || c == 15 || c == 16) begin
        n_chk++; if (rsp_valid_o !== 4'b0) $display("FAIL mag_rsp_quiet c%0d: got %b want 0000", c, rsp_valid_o); else n_pass++;
      end
      if (c >= 14) begin
        d = int'(rsp_data_o) - 32'h0005_0000;
        n_chk++; if (d < -2 || d > 2) $display("FAIL mag_rsp_data c%0d: got %h want 00050000 +-2", c, rsp_data_o); else n_pass++;
      end
      if (c == 14) begin
        n_chk++; if (rsp_valid_o !== 4'b0100) $display("FAIL mag_rsp_valid: got %b want 0100", rsp_valid_o); else n_pass++;
      end
    end
  endtask

  task automatic test_outstanding;
    logic [N-1:0] e;
    for (int c = 0; c < 38; c++) begin
      cyc();
      req_valid_i = (c <= 21) ? 4'b0010 : 4'b0000;
      #1;
      if (c <= 21) begin
        e = (c < 8 || c >= 14) ? 4'b0010 : 4'b0000;
        n_chk++; if (req_ready_o !== e) $display("FAIL outst_ready c%0d: got %b want %b", c, req_ready_o, e); else n_pass++;
      end
      if (c == 13 || c == 14) begin
        e = (c == 14) ? 4'b0010 : 4'b0000;
        n_chk++; if (rsp_valid_o !== e) $display("FAIL outst_rsp c%0d: got %b want %b", c, rsp_valid_o, e); else n_pass++;
      end
    end
  endtask

  task automatic test_flush;
    logic [N-1:0] e;
    for (int c = 0; c < 22; c++) begin
      cyc();
      req_valid_i = (c < 5 || (c >= 6 && c <= 17)) ? 4'hF : 4'h0;
      flush_i = (c == 5);
      #1;
      if (c < 5) begin
        e = 4'b0001 << ((c + 2) % 4);
        n_chk++; if (req_ready_o !== e) $display("FAIL flush_grant c%0d: got %b want %b", c, req_ready_o, e); else n_pass++;
      end
      if (c >= 6 && c <= 17) begin
        n_chk++; if (req_ready_o !== 4'b0) $display("FAIL flush_drain_ready c%0d: got %b want 0000", c, req_ready_o); else n_pass++;
      end
      if (c >= 14 && c <= 18) begin
        e = 4'b0001 << ((c - 14 + 2) % 4);
        n_chk++; if (rsp_valid_o !== e) $display("FAIL flush_rsp c%0d: got %b want %b", c, rsp_valid_o, e); else n_pass++;
      end
      if (c >= 18 && c <= 20) begin
        n_chk++; if (flush_done_o !== (c == 19)) $display("FAIL flush_done c%0d: got %b want %b", c, flush_done_o, (c == 19)); else n_pass++;
        n_chk++; if (idle_o !== (c >= 19)) $display("FAIL flush_idle c%0d: got %b want %b", c, idle_o, (c >= 19)); else n_pass++;
      end
    end
  endtask

  task automatic test_error;
    logic [N-1:0] e;
    for (int c = 0; c < 28; c++) begin
      cyc();
      inj = (c == 0);
      req_valid_i = (c >= 2 && c <= 10) ? 4'b0001 : 4'b0000;
      #1;
      if (c == 1) begin
        n_chk++; if (err_o !== 1'b1) $display("FAIL err_set: got %b want 1", err_o); else n_pass++;
        n_chk++; if (rsp_valid_o !== 4'b0) $display("FAIL err_no_rsp: got %b want 0000", rsp_valid_o); else n_pass++;
      end
      if (c >= 2 && c <= 10) begin
        e = (c <= 9) ? 4'b0001 : 4'b0000;
        n_chk++; if (req_ready_o !== e) $display("FAIL err_outst_ready c%0d: got %b want %b", c, req_ready_o, e); else n_pass++;
      end
    end
    n_chk++; if (err_o !== 1'b1) $display("FAIL err_sticky: got %b want 1", err_o); else n_pass++;
    n_chk++; if (grant_cnt_o !== (STATS ? 32'd35 : 32'd0)) $display("FAIL stats_grant: got %0d want %0d", grant_cnt_o, (STATS ? 35 : 0)); else n_pass++;
    n_chk++; if (stall_cnt_o !== (STATS ? 32'd19 : 32'd0)) $display("FAIL stats_stall: got %0d want %0d", stall_cnt_o, (STATS ? 19 : 0)); else n_pass++;
  endtask

  task automatic test_reset_mid;
    for (int c = 0; c < 22; c++) begin
      cyc();
      req_valid_i = (c < 6) ? 4'hF : 4'h0;
      rst_i = (c == 6);
      #1;
      if (c == 7) begin
        n_chk++; if (cdc_valid_o !== 1'b0 || cdc_x_o !== '0) $display("FAIL rstmid_cdc: got v=%b x=%h want 0 0", cdc_valid_o, cdc_x_o); else n_pass++;
        n_chk++; if (rsp_valid_o !== 4'b0 || rsp_data_o !== '0) $display("FAIL rstmid_rsp: got v=%b d=%h want 0 0", rsp_valid_o, rsp_data_o); else n_pass++;
        n_chk++; if (err_o !== 1'b0) $display("FAIL rstmid_err: got %b want 0", err_o); else n_pass++;
        n_chk++; if (idle_o !== 1'b1) $display("FAIL rstmid_idle: got %b want 1", idle_o); else n_pass++;
        n_chk++; if (req_ready_o !== 4'b0) $display("FAIL rstmid_ready: got %b want 0000", req_ready_o); else n_pass++;
        n_chk++; if (grant_cnt_o !== 32'd0) $display("FAIL rstmid_grant_cnt: got %0d want 0", grant_cnt_o); else n_pass++;
      end
      if (c == 13 || c == 14) begin
        n_chk++; if (err_o !== (c == 14)) $display("FAIL rstmid_late_err c%0d: got %b want %b", c, err_o, (c == 14)); else n_pass++;
      end
      if (c >= 14) begin
        n_chk++; if (rsp_valid_o !== 4'b0) $display("FAIL rstmid_no_rsp c%0d: got %b want 0000", c, rsp_valid_o); else n_pass++;
      end
    end
  endtask

  initial begin
    rst_i = 1'b1;
    req_valid_i = '0;
    req_x_i = '0;
    req_y_i = '0;
    flush_i = 1'b0;
    test_reset();
    test_round_robin();
    test_magnitude();
    test_outstanding();
    test_flush();
    test_error();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
